// File: rtl/updown_mod_counter_if.sv
// Control/status bundle for updown_mod_counter: the master drives the controls,
// the counter (slave) returns the registered count and its flags.
interface updown_mod_counter_if #(
  parameter int N = 8
);
  logic         clr;
  logic         load;
  logic [N-1:0] d;
  logic         en;
  logic         up;
  logic [N-1:0] q;
  logic         tc;
  logic         ovf;

  modport master (
    output clr, load, d, en, up,
    input  q, tc, ovf
  );

  modport slave (
    input  clr, load, d, en, up,
    output q, tc, ovf
  );
endinterface

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter over 0..MAXVAL with clear, clamped load, wrap or saturate
// at the bounds, a one-cycle terminal-count pulse and a sticky boundary flag.
module updown_mod_counter #(
  parameter int N        = 8,
  parameter int MAXVAL   = 2**N - 1,
  parameter bit SATURATE = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  updown_mod_counter_if.slave   bus
);

  localparam logic [N-1:0] MAX_C = N'(MAXVAL);
  localparam logic [N-1:0] ZERO  = '0;
  localparam logic [N-1:0] ONE   = N'(1);

  logic [N-1:0] q_q, q_d;
  logic         tc_q, tc_d;
  logic         ovf_q, ovf_d;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    q_d   = q_q;
    tc_d  = 1'b0;
    ovf_d = ovf_q;

    if (bus.clr) begin
      q_d   = ZERO;
      ovf_d = 1'b0;
    end else if (bus.load) begin
      // Out-of-range load values clamp so q never leaves 0..MAXVAL.
      q_d = (bus.d > MAX_C) ? MAX_C : bus.d;
    end else if (bus.en) begin
      if (bus.up) begin
        if (q_q == MAX_C) begin
          q_d   = SATURATE ? MAX_C : ZERO;
          tc_d  = 1'b1;
          ovf_d = 1'b1;
        end else begin
          q_d = q_q + ONE;
        end
      end else begin
        if (q_q == ZERO) begin
          q_d   = SATURATE ? ZERO : MAX_C;
          tc_d  = 1'b1;
          ovf_d = 1'b1;
        end else begin
          q_d = q_q - ONE;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q   <= ZERO;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.q   = q_q;
  assign bus.tc  = tc_q;
  assign bus.ovf = ovf_q;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter: a wrap-mode and a saturate-mode instance (N=4, MAXVAL=9)
// share stimulus; directed scenarios plus random traffic against an arithmetic model.
`timescale 1ns/100ps
module tb_updown_mod_counter;

  localparam int N    = 4;
  localparam int MAXV = 9;

  logic clk;
  logic reset_n;

  updown_mod_counter_if #(.N(N)) bus_w ();
  updown_mod_counter_if #(.N(N)) bus_s ();

  updown_mod_counter #(.N(N), .MAXVAL(MAXV), .SATURATE(1'b0)) dut_w (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_w.slave)
  );

  updown_mod_counter #(.N(N), .MAXVAL(MAXV), .SATURATE(1'b1)) dut_s (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_s.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference state; index 0 = wrap instance, 1 = saturate instance.
  int m_q   [2];
  int m_tc  [2];
  int m_ovf [2];

  initial clk = 1'b0;
  always #1 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_q[k] = 0; m_tc[k] = 0; m_ovf[k] = 0;
    end
  endtask

  // Next state from the rules: integer step, then wrap modulo MAXV+1 or clamp.
  task automatic model_step(input bit clr, input bit load, input int d, input bit en, input bit up);
    int nxt;
    for (int k = 0; k < 2; k++) begin
      m_tc[k] = 0;
      if (clr) begin
        m_q[k] = 0; m_ovf[k] = 0;
      end else if (load) begin
        m_q[k] = (d > MAXV) ? MAXV : d;
      end else if (en) begin
        nxt = m_q[k] + (up ? 1 : -1);
        if (nxt < 0 || nxt > MAXV) begin
          m_tc[k] = 1; m_ovf[k] = 1;
          if (k == 0) m_q[k] = (nxt + MAXV + 1) % (MAXV + 1);
          else        m_q[k] = (nxt < 0) ? 0 : MAXV;
        end else begin
          m_q[k] = nxt;
        end
      end
    end
  endtask

  // Drives both instances at the falling edge, clocks once, returns 1 unit after the edge.
  task automatic drive_cycle(input bit clr, input bit load, input int d, input bit en, input bit up);
    bus_w.clr = clr; bus_w.load = load; bus_w.d = N'(d); bus_w.en = en; bus_w.up = up;
    bus_s.clr = clr; bus_s.load = load; bus_s.d = N'(d); bus_s.en = en; bus_s.up = up;
    @(posedge clk);
    model_step(clr, load, d, en, up);
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    drive_cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) drive_cycle(0, 0, 0, 1, 1);
    checks++;
    if (bus_w.q !== 4'd5 || bus_w.ovf !== 1'b1) begin
      errors++;
      $display("FAIL reset_precount: got q=%0d ovf=%b, expected q=5 ovf=1", bus_w.q, bus_w.ovf);
    end
    #0.5 reset_n = 1'b0;
    #0.2;
    model_reset();
    checks++;
    if (bus_w.q !== 4'd0 || bus_w.tc !== 1'b0 || bus_w.ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: got q=%0d tc=%b ovf=%b, expected 0 0 0", bus_w.q, bus_w.tc, bus_w.ovf);
    end
    @(posedge clk); #1;
    checks++;
    if (bus_w.q !== 4'd0 || bus_s.q !== 4'd0) begin
      errors++;
      $display("FAIL reset_hold: got q_w=%0d q_s=%0d, expected 0 0", bus_w.q, bus_s.q);
    end
    reset_n = 1'b1;
    drive_cycle(0, 0, 0, 1, 1);
    checks++;
    if (bus_w.q !== 4'd1 || bus_w.tc !== 1'b0 || bus_w.ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_resume: got q=%0d tc=%b ovf=%b, expected q=1 tc=0 ovf=0", bus_w.q, bus_w.tc, bus_w.ovf);
    end
  endtask

  task automatic test_wrap_up();
    logic [3:0] exp_q;
    drive_cycle(1, 0, 0, 0, 0);
    for (int i = 1; i <= 12; i++) begin
      drive_cycle(0, 0, 0, 1, 1);
      exp_q = 4'(i % 10);
      checks++;
      if (bus_w.q !== exp_q || bus_w.tc !== (i == 10) || bus_w.ovf !== (i >= 10)) begin
        errors++;
        $display("FAIL wrap_up edge %0d: got q=%0d tc=%b ovf=%b, expected q=%0d tc=%b ovf=%b",
                 i, bus_w.q, bus_w.tc, bus_w.ovf, exp_q, (i == 10), (i >= 10));
      end
    end
  endtask

  task automatic test_wrap_down();
    logic [3:0] exp_q [3];
    logic       exp_tc[3];
    exp_q = '{4'd0, 4'd9, 4'd8};
    exp_tc = '{1'b0, 1'b1, 1'b0};
    drive_cycle(0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(0, 0, 0, 1, 0);
      checks++;
      if (bus_w.q !== exp_q[i] || bus_w.tc !== exp_tc[i]) begin
        errors++;
        $display("FAIL wrap_down edge %0d: got q=%0d tc=%b, expected q=%0d tc=%b",
                 i, bus_w.q, bus_w.tc, exp_q[i], exp_tc[i]);
      end
    end
  endtask

  task automatic test_saturate();
    drive_cycle(0, 1, 8, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive_cycle(0, 0, 0, 1, 1);
      checks++;
      if (bus_s.q !== 4'd9 || bus_s.tc !== (i != 0)) begin
        errors++;
        $display("FAIL sat_up edge %0d: got q=%0d tc=%b, expected q=9 tc=%b", i, bus_s.q, bus_s.tc, (i != 0));
      end
    end
    drive_cycle(0, 1, 0, 0, 0);
    drive_cycle(0, 0, 0, 1, 0);
    checks++;
    if (bus_s.q !== 4'd0 || bus_s.tc !== 1'b1 || bus_s.ovf !== 1'b1) begin
      errors++;
      $display("FAIL sat_down: got q=%0d tc=%b ovf=%b, expected q=0 tc=1 ovf=1", bus_s.q, bus_s.tc, bus_s.ovf);
    end
  endtask

  task automatic test_priority();
    drive_cycle(1, 1, 7, 1, 1);
    checks++;
    if (bus_w.q !== 4'd0 || bus_w.ovf !== 1'b0 || bus_s.ovf !== 1'b0) begin
      errors++;
      $display("FAIL prio_clr: got q=%0d ovf_w=%b ovf_s=%b, expected q=0 ovf 0 0", bus_w.q, bus_w.ovf, bus_s.ovf);
    end
    drive_cycle(0, 1, 15, 1, 1);
    checks++;
    if (bus_w.q !== 4'd9 || bus_w.tc !== 1'b0 || bus_s.q !== 4'd9) begin
      errors++;
      $display("FAIL prio_load_clamp: got q_w=%0d tc=%b q_s=%0d, expected q=9 tc=0 q_s=9", bus_w.q, bus_w.tc, bus_s.q);
    end
    drive_cycle(0, 0, 0, 0, 1);
    checks++;
    if (bus_w.q !== 4'd9 || bus_w.tc !== 1'b0) begin
      errors++;
      $display("FAIL prio_idle_hold: got q=%0d tc=%b, expected q=9 tc=0", bus_w.q, bus_w.tc);
    end
  endtask

  task automatic test_sticky();
    drive_cycle(0, 0, 0, 1, 1);
    checks++;
    if (bus_w.q !== 4'd0 || bus_w.tc !== 1'b1 || bus_w.ovf !== 1'b1) begin
      errors++;
      $display("FAIL sticky_set: got q=%0d tc=%b ovf=%b, expected q=0 tc=1 ovf=1", bus_w.q, bus_w.tc, bus_w.ovf);
    end
    drive_cycle(0, 1, 3, 0, 0);
    checks++;
    if (bus_w.q !== 4'd3 || bus_w.tc !== 1'b0 || bus_w.ovf !== 1'b1) begin
      errors++;
      $display("FAIL sticky_load: got q=%0d tc=%b ovf=%b, expected q=3 tc=0 ovf=1", bus_w.q, bus_w.tc, bus_w.ovf);
    end
    drive_cycle(1, 0, 0, 0, 0);
    checks++;
    if (bus_w.q !== 4'd0 || bus_w.ovf !== 1'b0) begin
      errors++;
      $display("FAIL sticky_clr: got q=%0d ovf=%b, expected q=0 ovf=0", bus_w.q, bus_w.ovf);
    end
  endtask

  task automatic test_random();
    bit clr, load, en, up;
    int d;
    for (int i = 0; i < 400; i++) begin
      clr  = ($urandom_range(0, 31) == 0);
      load = ($urandom_range(0, 7) == 0);
      en   = ($urandom_range(0, 3) != 0);
      up   = ($urandom_range(0, 99) < ((i / 50) % 2 == 0 ? 75 : 25));
      d    = $urandom_range(0, 15);
      drive_cycle(clr, load, d, en, up);
      checks++;
      if (bus_w.q !== 4'(m_q[0]) || bus_w.tc !== 1'(m_tc[0]) || bus_w.ovf !== 1'(m_ovf[0])) begin
        errors++;
        $display("FAIL random_wrap cycle %0d: got q=%0d tc=%b ovf=%b, expected q=%0d tc=%0d ovf=%0d",
                 i, bus_w.q, bus_w.tc, bus_w.ovf, m_q[0], m_tc[0], m_ovf[0]);
      end
      checks++;
      if (bus_s.q !== 4'(m_q[1]) || bus_s.tc !== 1'(m_tc[1]) || bus_s.ovf !== 1'(m_ovf[1])) begin
        errors++;
        $display("FAIL random_sat cycle %0d: got q=%0d tc=%b ovf=%b, expected q=%0d tc=%0d ovf=%0d",
                 i, bus_s.q, bus_s.tc, bus_s.ovf, m_q[1], m_tc[1], m_ovf[1]);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    bus_w.clr = 0; bus_w.load = 0; bus_w.d = '0; bus_w.en = 0; bus_w.up = 0;
    bus_s.clr = 0; bus_s.load = 0; bus_s.d = '0; bus_s.en = 0; bus_s.up = 0;
    model_reset();
    #0.5;
    checks++;
    if (bus_w.q !== 4'd0 || bus_w.tc !== 1'b0 || bus_w.ovf !== 1'b0 || bus_s.q !== 4'd0) begin
      errors++;
      $display("FAIL power_on_reset: got q_w=%0d tc=%b ovf=%b q_s=%0d, expected all 0",
               bus_w.q, bus_w.tc, bus_w.ovf, bus_s.q);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;

    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_saturate();
    test_priority();
    test_sticky();
    test_random();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
